// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR word generator with on-demand and free-running modes.
// Includes runtime seed load and all-zero lockup recovery.
module lfsr_gen #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0]   SEED  = 16'hBEEF,
    parameter int                 OUT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             mode,
    input  logic             req,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] out
);

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FREE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] step_r;

    // An all-zero register would lock up; recover to SEED on that step.
    always_comb begin
        if (r_q == '0) begin
            step_r = SEED;
        end else begin
            step_r = {r_q[WIDTH-2:0], ^(r_q & TAPS)};
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;

        if (load) begin
            r_d     = (seed_in == '0) ? SEED : seed_in;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else if (enable) begin
            unique case (state_q)
                S_IDLE: begin
                    if (mode) begin
                        state_d = S_FREE;
                    end else if (req) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN, S_FREE: begin
                    r_d = step_r;
                    if (cnt_q == LAST) begin
                        out_d   = step_r[OUT_W-1:0];
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        if (state_q == S_RUN || !mode) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            r_q     <= SEED;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign valid = valid_q;
    assign out   = out_q;

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR random-word generator for the flicker/effects datapath; next generation of the fixed 16-bit 4-bit-output generator.
- Width, tap mask, seed and output word width are parameters.
- Adds runtime seed load, all-zero lockup recovery, an on-demand request/valid word mode and a free-running mode with a word-boundary valid strobe.

Parameters:
- WIDTH, 16, LFSR length in bits (>= 3).
- TAPS, 16'hB400, feedback mask over WIDTH bits; feedback = XOR of r bits where mask is 1 (default taps 15,13,12,10).
- SEED, 16'hBEEF, reset and recovery value; must be non-zero.
- OUT_W, 4, output word width (1..WIDTH); also the number of steps per word.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  global advance enable; low freezes all state.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  runtime seed.
- mode  in  1  0 = on-demand, 1 = free-running; sampled only in IDLE.
- req  in  1  word request, mode 0; sampled only in IDLE.
- busy  out  1  high in RUN or FREE.
- valid  out  1  one-cycle strobe: out holds a fresh word.
- out  out  OUT_W  latest completed word.

Behaviour:
- Reset (async, reset_n=0):
  - r=SEED, step counter=0, FSM=IDLE.
  - out=0, valid=0, busy=0.
- Step:
  - r <= {r[WIDTH-2:0], ^(r & TAPS)}.
  - If r==0 at a step, r <= SEED instead; the counter still advances.
- Word completion:
  - On the step where counter==OUT_W-1: out <= low OUT_W bits of the post-step r, valid <= 1, counter <= 0.
  - valid is high for exactly the following cycle only; it drops even if enable falls.
- Priority per edge: reset > load > enable gating > FSM.
- load=1:
  - r <= seed_in, or SEED if seed_in==0.
  - counter=0, FSM -> IDLE, busy=0, valid=0, out unchanged.
  - Applies regardless of enable; mid-word abort, no valid issued.
- enable=0: r, counter, FSM and out hold; req/mode are ignored.
- FSM IDLE:
  - busy=0, no stepping.
  - If enable: mode=1 -> FREE; else req=1 -> RUN.
  - The transition edge performs no step.
- FSM RUN (mode 0):
  - busy=1; steps every enabled cycle.
  - On the OUT_W-th step: word completes, -> IDLE.
  - req ignored while busy.
  - Latency: req accepted at edge k; steps at k+1..k+OUT_W; valid high in the cycle after edge k+OUT_W.
  - Back-to-back: next req accepted no earlier than edge k+OUT_W+1.
- FSM FREE:
  - busy=1; steps every enabled cycle; valid strobe every OUT_W steps.
  - mode is re-sampled only at a word-completion edge: if 0 then -> IDLE on that edge, else stays FREE.
  - mode changes mid-word are ignored.
- Counter width: clog2(OUT_W) with a minimum of 1. OUT_W=1 gives a word every step.

Test Plan:
- Reset with defaults -> out=0, valid=0, busy=0; after 10 idle cycles r stays BEEF (no step).
- Single req, mode 0, enable=1:
  - busy high 4 cycles; r sequence 7DDE, FBBD, F77B, EEF6.
  - Then valid for one cycle with out=4'h6; busy=0.
- Second req after the first -> r DDED, BBDB, 77B7, EF6F; out=4'hF, valid one cycle.
- enable dropped for 3 cycles after step 2 of a word -> r holds FBBD, no valid; resumes and completes with out=4'h6, 3 cycles late.
- Load cases:
  - load with seed_in=0 mid-RUN -> r=BEEF, FSM IDLE, busy=0, no valid, out retains previous value.
  - load with seed_in=16'h0001 -> r=0001.
- mode=1 free-run:
  - valid pulses every 4 cycles, words 6, F, ...
  - mode dropped mid-word -> finishes the current word, valid, then IDLE with busy=0.
  - Async reset_n low mid-word -> immediate reset values.
